dist_ram_sdp_be: RTL and testbench

Parametrised simple-dual-port distributed RAM: one write port with byte enables, one read port, selectable read-during-write behaviour, optional output register, and a post-reset clear sweep. It is the generic LUT-RAM storage primitive for register files, small lookup tables and coefficient stores, used wherever a small memory must not consume a block RAM. Memory is declared with `ram_style = "distributed"`.

---
 rtl/dist_ram_sdp_be.sv | 148 ++++++++++++++
 tb/tb_dist_ram_sdp_be.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dist_ram_sdp_be.sv
// dist_ram_sdp_be: simple-dual-port LUT RAM with byte-enable writes.
//   One write port with per-lane enables and one read port. Collision
//   behaviour is chosen by RD_MODE. OUT_REG adds an optional output register.
//   When CLEAR_ON_RESET=1, every word is zeroed after reset.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   wr_en/addr/be/data     write request; lane i = wr_data[i*BYTE_W +: BYTE_W]
//   rd_en/addr             read request
//   rd_data, rd_valid      read result (held between reads), one-cycle valid
//   init_busy              clear sweep running; requests are ignored

// One byte lane of the collision merge: the new byte if enabled, else the old one.
module dist_ram_be_lane #(
  parameter int BYTE_W = 8
) (
  input  logic              en,
  input  logic [BYTE_W-1:0] old_byte,
  input  logic [BYTE_W-1:0] new_byte,
  output logic [BYTE_W-1:0] merged
);
  assign merged = en ? new_byte : old_byte;
endmodule

module dist_ram_sdp_be #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int BYTE_W         = 8,
  parameter int RD_MODE        = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W/BYTE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       init_busy
);
  localparam int NBE    = DATA_W / BYTE_W;
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last, clr_we, run;

  assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));

  // FSM: state register and sweep counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
    end
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_last) state_nx = RUN;
  end

  // FSM: outputs
  always_comb begin
    init_busy = (state == CLEAR);
    clr_we    = (state == CLEAR);
    run       = (state == RUN);
  end

  // Address range checks. The addresses are widened to 32 bits so that a
  // non-power-of-two DEPTH compares correctly.
  logic wr_ok, rd_ok, rd_in, hit;
  assign wr_ok = run && wr_en && (32'(wr_addr) < DEPTH);
  assign rd_ok = run && rd_en;
  assign rd_in = (32'(rd_addr) < DEPTH);
  assign hit   = (RD_MODE == 1) && wr_ok && (wr_addr == rd_addr);

  // Memory write: the sweep has priority. No write happens while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) begin
        mem[clr_cnt] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < NBE; i++)
          if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Asynchronous LUT read. The array holds the pre-write word, so read-first
  // behaviour needs no extra logic. Write-first merges the enabled lanes.
  logic [DATA_W-1:0] rd_old, rd_word;
  logic [NBE-1:0]    lane_en;
  assign rd_old  = rd_in ? mem[rd_addr] : '0;
  assign lane_en = wr_be & {NBE{hit}};

  dist_ram_be_lane #(.BYTE_W(BYTE_W)) u_lane [NBE-1:0] (
    .en       (lane_en),
    .old_byte (rd_old),
    .new_byte (wr_data),
    .merged   (rd_word)
  );

  // Read pipeline. Each stage register loads only on its valid, so rd_data
  // keeps its last value between reads.
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  logic [DATA_W-1:0] s1_data;

  assign vld_pipe = {vld_q, rd_ok};
  assign rd_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      s1_data <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (rd_ok) s1_data <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] s2_data;
      always_ff @(posedge clk) begin
        if (!rst_n)          s2_data <= '0;
        else if (vld_pipe[1]) s2_data <= s1_data;
      end
      assign rd_data = s2_data;
    end else begin : g_noreg
      assign rd_data = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_dist_ram_sdp_be.sv
module tb_dist_ram_sdp_be;
  // DUT a: DEPTH 256, read-first, latency 1.
  // DUT b: DEPTH 200, write-first, latency 2.
  // Both DUTs share the same stimulus.
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0]  wr_addr = '0, rd_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

  always #5 clk = ~clk;

  dist_ram_sdp_be #(.DATA_W(32), .DEPTH(256), .BYTE_W(8), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(busy_a));

  dist_ram_sdp_be #(.DATA_W(32), .DEPTH(200), .BYTE_W(8), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(busy_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  bit run = 1'b0;   // both DUTs out of the sweep, so requests are accepted

  // Reference model
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [200];
  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t qa[$], qb[$];

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mem_a[i] = '0;
    for (int i = 0; i < 200; i++) mem_b[i] = '0;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus. This task is called at a negedge and returns at the next negedge.
  task automatic step(bit we, logic [7:0] wa, logic [3:0] be, logic [31:0] wd, bit re, logic [7:0] ra);
    logic [31:0] ea, eb;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
    if (run) begin
      if (re) begin
        ea = mem_a[ra];
        if (ra < 200) begin
          eb = mem_b[ra];
          if (we && wa == ra) eb = merge(eb, wd, be);
        end else eb = '0;
        qa.push_back('{ea, cyc + 1});
        qb.push_back('{eb, cyc + 2});
      end
      if (we) begin
        mem_a[wa] = merge(mem_a[wa], wd, be);
        if (wa < 200) mem_b[wa] = merge(mem_b[wa], wd, be);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_state();
    check("rst_valid_a", {31'd0, rd_valid_a}, 0);
    check("rst_data_a", rd_data_a, 0);
    check("rst_busy_a", {31'd0, busy_a}, 1);
    check("rst_valid_b", {31'd0, rd_valid_b}, 0);
    check("rst_data_b", rd_data_b, 0);
    check("rst_busy_b", {31'd0, busy_b}, 1);
  endtask

  // Counts edges from the reset release until init_busy drops.
  task automatic wait_clear();
    int na = 0, nb = 0;
    for (int n = 1; n <= 400 && (na == 0 || nb == 0); n++) begin
      @(negedge clk);
      if (!busy_a && na == 0) na = n;
      if (!busy_b && nb == 0) nb = n;
    end
    check("clear_len_a", na, 256);
    check("clear_len_b", nb, 200);
    run = 1'b1;
  endtask

  task automatic do_reset();
    idle(3);
    run = 1'b0;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    wait_clear();
  endtask

  // Monitor: pops the expectation on each valid, and checks hold otherwise.
  exp_t e;
  logic [31:0] last_a = '0, last_b = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete(); qb.delete(); last_a = '0; last_b = '0;
    end else begin
      n_tests++;
      if (rd_valid_a) begin
        if (qa.size() == 0) begin
          n_fail++; $display("FAIL a_unexpected_valid: got data %h at cycle %0d, expected no valid", rd_data_a, cyc);
        end else begin
          e = qa.pop_front();
          if (rd_data_a !== e.d || cyc != e.c) begin
            n_fail++; $display("FAIL a_read: got %h at cycle %0d, expected %h at cycle %0d", rd_data_a, cyc, e.d, e.c);
          end
        end
        last_a = rd_data_a;
      end else if (rd_data_a !== last_a) begin
        n_fail++; $display("FAIL a_hold: got %h expected %h", rd_data_a, last_a);
      end
      n_tests++;
      if (rd_valid_b) begin
        if (qb.size() == 0) begin
          n_fail++; $display("FAIL b_unexpected_valid: got data %h at cycle %0d, expected no valid", rd_data_b, cyc);
        end else begin
          e = qb.pop_front();
          if (rd_data_b !== e.d || cyc != e.c) begin
            n_fail++; $display("FAIL b_read: got %h at cycle %0d, expected %h at cycle %0d", rd_data_b, cyc, e.d, e.c);
          end
        end
        last_b = rd_data_b;
      end else if (rd_data_b !== last_b) begin
        n_fail++; $display("FAIL b_hold: got %h expected %h", rd_data_b, last_b);
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Preload a word, then reset: the sweep must zero it.
    step(1, 5, 4'hF, 32'hDEADBEEF, 0, 0);
    step(0, 0, 0, 0, 1, 5);
    do_reset();
    step(0, 0, 0, 0, 1, 5);

    // Byte enables
    step(1, 3, 4'hF, 32'h11223344, 0, 0);
    step(1, 3, 4'b0101, 32'hAABBCCDD, 0, 0);
    step(0, 0, 0, 0, 1, 3);

    // Collision: a returns the old word, b returns the merged word.
    step(1, 7, 4'hF, 32'h0, 0, 0);
    step(1, 7, 4'hF, 32'hCAFEF00D, 1, 7);
    step(1, 7, 4'b0011, 32'h5555AAAA, 1, 7);
    step(0, 0, 0, 0, 1, 7);

    // Back-to-back reads; the cycle check covers latency.
    step(1, 0, 4'hF, 32'h0A0A0A0A, 0, 0);
    step(1, 1, 4'hF, 32'h1B1B1B1B, 0, 0);
    step(1, 2, 4'hF, 32'h2C2C2C2C, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 2);

    // Out of range for b (in range for a), then sweep all addresses.
    step(1, 210, 4'hF, 32'h12345678, 0, 0);
    for (int a = 0; a < 256; a++) step(0, 0, 0, 0, 1, a[7:0]);

    // Randomized traffic biased towards collisions.
    repeat (400) begin
      logic [7:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ra = 8'($urandom_range(190, 255));
      step($urandom_range(0, 1) == 1, wa, 4'($urandom), $urandom, $urandom_range(0, 2) != 0, ra);
    end

    // Reset in the middle of the sweep; requests issued while busy must be ignored.
    idle(3);
    run = 1'b0;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) step(1, 8'($urandom_range(0, 15)), 4'hF, $urandom, 1, 8'($urandom_range(0, 15)));
    wr_en = 1'b0; rd_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    wait_clear();
    for (int a = 0; a < 16; a++) step(0, 0, 0, 0, 1, a[7:0]);

    idle(5);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
